thermo_fine_encoder: RTL and testbench

Converts the raw tap vector of the CAN delay line into the 7-bit fine-time code consumed by the record packer that feeds the timestamp FIFO. It samples the thermometer vector every CLK cycle and detects a CAN_logic transition entering the line. For each detected edge it emits a one-cycle-valid fine code, the edge polarity and a saturation flag, at a fixed pipeline latency. It sits between the tapped delay line flops and the `{CAN_ID_and_coarse_time, fine_time}` packing.

---
 rtl/tdc_pkg.sv | 14 +
 rtl/thermo_fine_encoder_if.sv | 14 +
 rtl/thermo_fine_encoder_popcount_group.sv | 23 ++
 rtl/thermo_fine_encoder.sv | 126 ++++++++++++
 tb/tb_thermo_fine_encoder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC fine-time path.
package tdc_pkg;
  localparam int unsigned TDC_TAPS      = 128;
  localparam int unsigned TDC_FINE_W    = 7;
  localparam int unsigned TDC_GROUP_W   = 32;
  localparam int unsigned TDC_GRP_CNT_W = $clog2(TDC_GROUP_W + 1);
`ifdef THERMO_BUBBLE_FILTER_EN
  localparam int unsigned TDC_LATENCY   = 4;
`else
  localparam int unsigned TDC_LATENCY   = 3;
`endif

  typedef logic [TDC_FINE_W-1:0] fine_code_t;
endpackage

// File: rtl/thermo_fine_encoder_if.sv
// Tap-vector input and fine-code result bundle of the thermometer encoder.
interface thermo_fine_encoder_if #(
  parameter int unsigned TAPS   = tdc_pkg::TDC_TAPS,
  parameter int unsigned FINE_W = tdc_pkg::TDC_FINE_W
);
  logic [TAPS-1:0]   taps;
  logic [FINE_W-1:0] fine_time;
  logic              fine_valid;
  logic              edge_pol;
  logic              fine_sat;

  modport master (output taps, input fine_time, fine_valid, edge_pol, fine_sat);
  modport slave  (input taps, output fine_time, fine_valid, edge_pol, fine_sat);
endinterface

// File: rtl/thermo_fine_encoder_popcount_group.sv
// Registered count of bits in one 32-bit tap group that equal the reference tap.
module popcount_group
  import tdc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TDC_GROUP_W-1:0]   bits,
  input  logic                     ref_bit,
  output logic [TDC_GRP_CNT_W-1:0] count
);
  logic [TDC_GRP_CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < TDC_GROUP_W; i++)
      count_d = count_d + TDC_GRP_CNT_W'(bits[i] == ref_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_d;
  end
endmodule

// File: rtl/thermo_fine_encoder.sv
// Thermometer tap vector to fine-time code; optional majority bubble filter
// enabled with `define THERMO_BUBBLE_FILTER_EN (adds one pipeline stage).
module thermo_fine_encoder
  import tdc_pkg::*;
#(
  parameter int unsigned TAPS   = TDC_TAPS,
  parameter int unsigned FINE_W = TDC_FINE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  thermo_fine_encoder_if.slave  bus
);
  localparam int unsigned GROUPS = TAPS / TDC_GROUP_W;
  localparam int unsigned CNT_W  = $clog2(TAPS + 1);

  logic [TAPS-1:0] s1_taps;
  logic            s1_evt, s1_pol;
  logic            prev_tap0, prev_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_taps   <= '0;
      s1_evt    <= 1'b0;
      s1_pol    <= 1'b0;
      prev_tap0 <= 1'b0;
      prev_ok   <= 1'b0;
    end else begin
      s1_taps   <= bus.taps;
      s1_evt    <= prev_ok && (bus.taps[0] != prev_tap0);
      s1_pol    <= bus.taps[0];
      prev_tap0 <= bus.taps[0];
      prev_ok   <= 1'b1;
    end
  end

  logic [TAPS-1:0] c_taps;
  logic            c_evt, c_pol;

`ifdef THERMO_BUBBLE_FILTER_EN
  logic [TAPS-1:0] filt, sf_taps;
  logic            sf_evt, sf_pol;

  // End taps pass through; tap 0 stays raw so the match reference is unfiltered.
  always_comb begin
    filt = s1_taps;
    for (int unsigned i = 1; i < TAPS - 1; i++)
      filt[i] = (s1_taps[i-1] & s1_taps[i]) | (s1_taps[i] & s1_taps[i+1]) |
                (s1_taps[i-1] & s1_taps[i+1]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sf_taps <= '0;
      sf_evt  <= 1'b0;
      sf_pol  <= 1'b0;
    end else begin
      sf_taps <= filt;
      sf_evt  <= s1_evt;
      sf_pol  <= s1_pol;
    end
  end

  assign c_taps = sf_taps;
  assign c_evt  = sf_evt;
  assign c_pol  = sf_pol;
`else
  assign c_taps = s1_taps;
  assign c_evt  = s1_evt;
  assign c_pol  = s1_pol;
`endif

  logic [TDC_GRP_CNT_W-1:0] grp_cnt [GROUPS];
  logic                     s2_evt, s2_pol;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    popcount_group u_grp (
      .clk     (CLK),
      .rst     (RST),
      .bits    (c_taps[g*TDC_GROUP_W +: TDC_GROUP_W]),
      .ref_bit (c_taps[0]),
      .count   (grp_cnt[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_evt <= 1'b0;
      s2_pol <= 1'b0;
    end else begin
      s2_evt <= c_evt;
      s2_pol <= c_pol;
    end
  end

  logic [CNT_W-1:0] count_sum;

  always_comb begin
    count_sum = '0;
    for (int unsigned g = 0; g < GROUPS; g++)
      count_sum = count_sum + CNT_W'(grp_cnt[g]);
  end

  logic [FINE_W-1:0] fine_time_q;
  logic              fine_valid_q, edge_pol_q, fine_sat_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fine_time_q  <= '0;
      fine_valid_q <= 1'b0;
      edge_pol_q   <= 1'b0;
      fine_sat_q   <= 1'b0;
    end else begin
      fine_valid_q <= s2_evt;
      if (s2_evt) begin
        fine_time_q <= FINE_W'(count_sum - CNT_W'(1));
        edge_pol_q  <= s2_pol;
        fine_sat_q  <= (count_sum == CNT_W'(TAPS));
      end
    end
  end

  assign bus.fine_time  = fine_time_q;
  assign bus.fine_valid = fine_valid_q;
  assign bus.edge_pol   = edge_pol_q;
  assign bus.fine_sat   = fine_sat_q;
endmodule

// File: tb/tb_thermo_fine_encoder.sv
// Directed-vector self-checking bench for thermo_fine_encoder.
module tb_thermo_fine_encoder;
  import tdc_pkg::*;

  localparam int unsigned LAT = TDC_LATENCY;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  thermo_fine_encoder_if #(.TAPS(TDC_TAPS), .FINE_W(TDC_FINE_W)) bus ();

  thermo_fine_encoder #(.TAPS(TDC_TAPS), .FINE_W(TDC_FINE_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Call right after presenting the vector that carries the edge.
  task automatic expect_event(input string tag, input fine_code_t t,
                              input logic pol, input logic sat);
    for (int i = 1; i < LAT; i++) begin
      step();
      check({tag, "_early"}, 32'(bus.fine_valid), 32'd0);
    end
    step();
    check({tag, "_valid"}, 32'(bus.fine_valid), 32'd1);
    check({tag, "_time"},  32'(bus.fine_time),  32'(t));
    check({tag, "_pol"},   32'(bus.edge_pol),   32'(pol));
    check({tag, "_sat"},   32'(bus.fine_sat),   32'(sat));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [TDC_TAPS-1:0] v;

  initial begin
    bus.taps = '0;
    settle(3);
    check("rst_time",  32'(bus.fine_time),  32'd0);
    check("rst_valid", 32'(bus.fine_valid), 32'd0);
    check("rst_pol",   32'(bus.edge_pol),   32'd0);
    check("rst_sat",   32'(bus.fine_sat),   32'd0);
    RST = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_valid", 32'(bus.fine_valid), 32'd0);
      check("idle_time",  32'(bus.fine_time),  32'd0);
    end

    // 8 ones at the low end: rising edge, code 7
    bus.taps = 128'hFF;
    expect_event("r8", 7'd7, 1'b1, 1'b0);
    step();
    check("r8_pulse_end", 32'(bus.fine_valid), 32'd0);
    check("r8_hold",      32'(bus.fine_time),  32'd7);

    // all-ones keeps tap0 at 1: no event
    bus.taps = '1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      check("ones_noevt", 32'(bus.fine_valid), 32'd0);
    end

    // low 40 bits 0: falling edge, 40 matching taps
    v = '1;
    v[39:0] = '0;
    bus.taps = v;
    expect_event("f40", 7'd39, 1'b0, 1'b0);
    bus.taps = '0;
    settle(LAT + 2);

    // back-to-back: 0x1 rising (1 match), then 0x2 falling
    bus.taps = 128'h1;
    step();
    check("b2b_early0", 32'(bus.fine_valid), 32'd0);
    bus.taps = 128'h2;
    for (int i = 2; i < LAT; i++) begin
      step();
      check("b2b_early", 32'(bus.fine_valid), 32'd0);
    end
    step();
    check("b2b1_valid", 32'(bus.fine_valid), 32'd1);
    check("b2b1_time",  32'(bus.fine_time),  32'd0);
    check("b2b1_pol",   32'(bus.edge_pol),   32'd1);
    check("b2b1_sat",   32'(bus.fine_sat),   32'd0);
    step();
    check("b2b2_valid", 32'(bus.fine_valid), 32'd1);
`ifdef THERMO_BUBBLE_FILTER_EN
    // isolated bit 1 is voted away: all 128 taps match
    check("b2b2_time",  32'(bus.fine_time),  32'd127);
    check("b2b2_sat",   32'(bus.fine_sat),   32'd1);
`else
    check("b2b2_time",  32'(bus.fine_time),  32'd126);
    check("b2b2_sat",   32'(bus.fine_sat),   32'd0);
`endif
    check("b2b2_pol",   32'(bus.edge_pol),   32'd0);
    step();
    check("b2b_end",    32'(bus.fine_valid), 32'd0);
    bus.taps = '0;
    settle(LAT + 2);

    // saturating rising edge
    bus.taps = '1;
    expect_event("sat", 7'd127, 1'b1, 1'b1);
    settle(2);

    // falling edge, then reset one cycle later: event must vanish
    bus.taps = '0;
    step();
    RST = 1'b1;
    bus.taps = '1;
    step();
    RST = 1'b0;
    check("rst_mid_time", 32'(bus.fine_time), 32'd0);
    check("rst_mid_sat",  32'(bus.fine_sat),  32'd0);
    check("rst_mid_pol",  32'(bus.edge_pol),  32'd0);
    // tap0 is 1 while the reset value of prev_tap0 is 0: still no event
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      check("rst_mid_noevt", 32'(bus.fine_valid), 32'd0);
    end

    // falling edge to clear, then bubble at bit 3
    bus.taps = '0;
    expect_event("clr", 7'd127, 1'b0, 1'b1);
    settle(2);
    bus.taps = 128'hF7;
`ifdef THERMO_BUBBLE_FILTER_EN
    expect_event("bub", 7'd7, 1'b1, 1'b0);
`else
    expect_event("bub", 7'd6, 1'b1, 1'b0);
`endif
    step();
    check("bub_end", 32'(bus.fine_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
